seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
- Holds a shadow copy of per-digit 5-bit symbols and decimal points.
- Steps through digits at a divided rate and presents one digit's symbol/dp to the downstream symbol-to-segment decoder, plus an active-low digit enable.
- Adds leading-zero suppression, per-digit blink, inter-digit dead time and a frame-start strobe.

---
 rtl/seg_pkg.sv | 15 +
 rtl/clk_div_tick.sv | 33 +++
 rtl/seg_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller: symbol encoding
// and the active-low digit-enable helper.
package seg_pkg;

  localparam int unsigned SYM_W      = 5;
  localparam int unsigned MAX_DIGITS = 8;

  localparam logic [SYM_W-1:0] SYM_SPECIAL = 5'd16;
  localparam logic [SYM_W-1:0] SYM_ZERO    = 5'd0;

  function automatic logic [MAX_DIGITS-1:0] an_onehot_low(input logic [2:0] idx);
    return ~(MAX_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/clk_div_tick.sv
// Enabled modulo-DIV counter; tick is high for the enabled cycle on which
// the counter sits at DIV-1 and is about to wrap.
module clk_div_tick #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned     CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == CNT_MAX);
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment
// display with shadowed data, leading-zero suppression, blink and dead time.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned CLK_DIV     = 50000,
  parameter int unsigned BLINK_TICKS = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [SYM_W*N_DIGITS-1:0] sym_in,
  input  logic [N_DIGITS-1:0]       dp_in,
  input  logic [N_DIGITS-1:0]       blink_in,
  input  logic                      lzs_en,
  output logic [SYM_W-1:0]          symbol,
  output logic                      dp,
  output logic [N_DIGITS-1:0]       an,
  output logic                      frame_start
);

  localparam int unsigned       IDX_W    = $clog2(N_DIGITS);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic tick;
  logic blink_wrap;

  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      phase_q, phase_d;
  logic                      wrap_pend_q, wrap_pend_d;
  logic [SYM_W*N_DIGITS-1:0] sym_sh_q, sym_sh_d;
  logic [N_DIGITS-1:0]       dp_sh_q, dp_sh_d;
  logic [N_DIGITS-1:0]       blink_sh_q, blink_sh_d;
  logic [SYM_W-1:0]          symbol_q, symbol_d;
  logic                      dp_q, dp_d;
  logic [N_DIGITS-1:0]       an_q, an_d;
  logic                      fs_q, fs_d;

  logic [SYM_W-1:0]    sym_arr [N_DIGITS];
  logic [N_DIGITS-1:0] lz_mask;
  logic [N_DIGITS-1:0] blank;
  logic                zero_run;

  clk_div_tick #(.DIV(CLK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .tick  (tick)
  );

  clk_div_tick #(.DIV(BLINK_TICKS)) u_blink_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick),
    .tick  (blink_wrap)
  );

  // Suppression walks from the most significant digit down; the first
  // non-zero symbol (including the special glyph) or set dp ends the run.
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int unsigned d = 0; d < N_DIGITS; d++) begin
      sym_arr[d] = sym_sh_q[SYM_W*d +: SYM_W];
    end
    for (int unsigned k = 0; k < N_DIGITS - 1; k++) begin
      zero_run = zero_run && (sym_arr[N_DIGITS-1-k] == SYM_ZERO) && !dp_sh_q[N_DIGITS-1-k];
      lz_mask[N_DIGITS-1-k] = zero_run;
    end
    blank = (blink_sh_q & {N_DIGITS{phase_q}}) | (lz_mask & {N_DIGITS{lzs_en}});
  end

  always_comb begin
    idx_d       = idx_q;
    phase_d     = phase_q ^ blink_wrap;
    wrap_pend_d = wrap_pend_q;
    an_d        = an_q;
    symbol_d    = symbol_q;
    dp_d        = dp_q;
    fs_d        = 1'b0;
    sym_sh_d    = load ? sym_in   : sym_sh_q;
    dp_sh_d     = load ? dp_in    : dp_sh_q;
    blink_sh_d  = load ? blink_in : blink_sh_q;

    if (tick) begin
      idx_d       = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      an_d        = '1;
      wrap_pend_d = (idx_q == IDX_LAST);
    end else begin
      fs_d        = wrap_pend_q;
      wrap_pend_d = 1'b0;
      if (blank[idx_q]) begin
        an_d     = '1;
        symbol_d = '0;
        dp_d     = 1'b0;
      end else begin
        an_d     = N_DIGITS'(an_onehot_low(3'(idx_q)));
        symbol_d = sym_arr[idx_q];
        dp_d     = dp_sh_q[idx_q];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      phase_q     <= 1'b0;
      wrap_pend_q <= 1'b0;
      sym_sh_q    <= '0;
      dp_sh_q     <= '0;
      blink_sh_q  <= '0;
      symbol_q    <= '0;
      dp_q        <= 1'b0;
      an_q        <= '1;
      fs_q        <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      phase_q     <= phase_d;
      wrap_pend_q <= wrap_pend_d;
      sym_sh_q    <= sym_sh_d;
      dp_sh_q     <= dp_sh_d;
      blink_sh_q  <= blink_sh_d;
      symbol_q    <= symbol_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
      fs_q        <= fs_d;
    end
  end

  assign symbol      = symbol_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: expected lit-digit runs are queued by
// the stimulus and checked by a monitor as each run ends.
module tb_seg_scan_ctrl;

  localparam int unsigned N   = 4;
  localparam int unsigned DIV = 4;
  localparam int unsigned BT  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [19:0] sym_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_in = '0;
  logic        lzs_en = 1'b0;
  logic [4:0]  symbol;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.N_DIGITS(N), .CLK_DIV(DIV), .BLINK_TICKS(BT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .sym_in      (sym_in),
    .dp_in       (dp_in),
    .blink_in    (blink_in),
    .lzs_en      (lzs_en),
    .symbol      (symbol),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [4:0] sym;
    logic       dp;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // monitor state
  bit         in_run = 0;
  bit         tracked = 0;
  bit         steady = 1;
  int         run_len = 0;
  logic [3:0] r_an;
  logic [4:0] r_sym;
  logic       r_dp;
  logic       r_fs;
  exp_t       m_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_run = 0;
    end else begin
      if (in_run && an !== r_an) begin
        in_run = 0;
        if (tracked) begin
          m_e = exp_q.pop_front();
          tests++;
          if (r_an !== m_e.an || r_sym !== m_e.sym || r_dp !== m_e.dp || r_fs !== m_e.fs ||
              run_len != DIV - 1 || !steady) begin
            fails++;
            $display("FAIL run: got an=%b sym=%0d dp=%b fs=%b len=%0d steady=%0b, expected an=%b sym=%0d dp=%b fs=%b len=%0d steady=1",
                     r_an, r_sym, r_dp, r_fs, run_len, steady, m_e.an, m_e.sym, m_e.dp, m_e.fs, DIV - 1);
          end
        end
      end
      if (!in_run && an !== 4'b1111) begin
        in_run  = 1;
        tracked = (exp_q.size() > 0);
        r_an    = an;
        r_sym   = symbol;
        r_dp    = dp;
        r_fs    = frame_start;
        run_len = 1;
        steady  = 1;
      end else if (in_run) begin
        run_len++;
        if (symbol !== r_sym || dp !== r_dp || frame_start !== 1'b0) steady = 0;
      end
    end
  end

  function automatic void push(input logic [3:0] a, input logic [4:0] s, input logic d, input logic f);
    exp_t e;
    e.an  = a;
    e.sym = s;
    e.dp  = d;
    e.fs  = f;
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  task automatic timeout(input string what, input int waited);
    tests++;
    fails++;
    $display("FAIL %s: no event after %0d cycles, expected one within that bound", what, waited);
  endtask

  task automatic wait_fs();
    bit ok = 0;
    int n = 0;
    while (!ok && n < 64) begin
      @(negedge clk);
      n++;
      ok = (frame_start === 1'b1);
    end
    if (!ok) timeout("wait_frame_start", n);
  endtask

  task automatic wait_an(input logic [3:0] v, input string what);
    bit ok = 0;
    int n = 0;
    while (!ok && n < 64) begin
      if (an === v) ok = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (!ok) timeout(what, n);
  endtask

  task automatic wait_drain(input string what);
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      timeout(what, n);
      exp_q.delete();
    end
  endtask

  // mode 0: load mid-slot; 1: back-to-back loads, last wins; 2: load on the tick edge
  task automatic load_at_frame(input logic [19:0] s, input logic [3:0] d, input logic [3:0] b,
                               input logic lz, input int mode);
    wait_fs();
    if (mode == 1) begin
      sym_in   = ~s;
      dp_in    = ~d;
      blink_in = 4'b0000;
      load     = 1'b1;
      @(negedge clk);
    end else if (mode == 2) begin
      @(negedge clk);
      @(negedge clk);
    end
    sym_in   = s;
    dp_in    = d;
    blink_in = b;
    lzs_en   = lz;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_an(4'b1111, "wait_dead_after_digit0");
  endtask

  initial begin
    // reset scan
    repeat (2) @(negedge clk);
    push(4'b1110, 5'd0, 1'b0, 1'b0);
    push(4'b1101, 5'd0, 1'b0, 1'b0);
    push(4'b1011, 5'd0, 1'b0, 1'b0);
    push(4'b0111, 5'd0, 1'b0, 1'b0);
    push(4'b1110, 5'd0, 1'b0, 1'b1);
    check("reset_an", {4'b0, an}, 8'b0000_1111);
    check("reset_sym_dp_fs", {1'b0, symbol, dp, frame_start}, 8'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_cycle_an", {4'b0, an}, 8'b0000_1110);
    wait_drain("reset_scan");

    // values, back-to-back load
    load_at_frame({5'd3, 5'd2, 5'd1, 5'd0}, 4'b0100, 4'b0000, 1'b0, 1);
    push(4'b1101, 5'd1, 1'b0, 1'b0);
    push(4'b1011, 5'd2, 1'b1, 1'b0);
    push(4'b0111, 5'd3, 1'b0, 1'b0);
    push(4'b1110, 5'd0, 1'b0, 1'b1);
    push(4'b1101, 5'd1, 1'b0, 1'b0);
    wait_drain("load_values");

    // leading zeros suppressed
    load_at_frame({5'd0, 5'd0, 5'd7, 5'd0}, 4'b0000, 4'b0000, 1'b1, 0);
    push(4'b1101, 5'd7, 1'b0, 1'b0);
    push(4'b1110, 5'd0, 1'b0, 1'b1);
    push(4'b1101, 5'd7, 1'b0, 1'b0);
    wait_drain("lzs_on");

    // suppression disabled
    load_at_frame({5'd0, 5'd0, 5'd7, 5'd0}, 4'b0000, 4'b0000, 1'b0, 0);
    push(4'b1101, 5'd7, 1'b0, 1'b0);
    push(4'b1011, 5'd0, 1'b0, 1'b0);
    push(4'b0111, 5'd0, 1'b0, 1'b0);
    push(4'b1110, 5'd0, 1'b0, 1'b1);
    wait_drain("lzs_off");

    // dp on top digit stops suppression
    load_at_frame({5'd0, 5'd0, 5'd7, 5'd0}, 4'b1000, 4'b0000, 1'b1, 0);
    push(4'b1101, 5'd7, 1'b0, 1'b0);
    push(4'b1011, 5'd0, 1'b0, 1'b0);
    push(4'b0111, 5'd0, 1'b1, 1'b0);
    push(4'b1110, 5'd0, 1'b0, 1'b1);
    wait_drain("lzs_dp");

    // special glyph stops suppression
    load_at_frame({5'd0, 5'd16, 5'd0, 5'd0}, 4'b0000, 4'b0000, 1'b1, 0);
    push(4'b1101, 5'd0, 1'b0, 1'b0);
    push(4'b1011, 5'd16, 1'b0, 1'b0);
    push(4'b1110, 5'd0, 1'b0, 1'b1);
    push(4'b1101, 5'd0, 1'b0, 1'b0);
    wait_drain("special_glyph");

    // load on the tick edge, pass-through of high symbol codes
    load_at_frame({5'd31, 5'd17, 5'd4, 5'd9}, 4'b0000, 4'b0000, 1'b1, 2);
    push(4'b1101, 5'd4, 1'b0, 1'b0);
    push(4'b1011, 5'd17, 1'b0, 1'b0);
    push(4'b0111, 5'd31, 1'b0, 1'b0);
    push(4'b1110, 5'd9, 1'b0, 1'b1);
    wait_drain("tick_load");

    // blink: slots 2-3 fall in phase 1, slots 0-1 in phase 0
    load_at_frame({5'd4, 5'd3, 5'd2, 5'd1}, 4'b0000, 4'b0101, 1'b0, 0);
    push(4'b1101, 5'd2, 1'b0, 1'b0);
    push(4'b0111, 5'd4, 1'b0, 1'b0);
    push(4'b1110, 5'd1, 1'b0, 1'b1);
    push(4'b1101, 5'd2, 1'b0, 1'b0);
    push(4'b0111, 5'd4, 1'b0, 1'b0);
    push(4'b1110, 5'd1, 1'b0, 1'b1);
    wait_drain("blink_0101");

    load_at_frame({5'd4, 5'd3, 5'd2, 5'd1}, 4'b0000, 4'b1000, 1'b0, 0);
    push(4'b1101, 5'd2, 1'b0, 1'b0);
    push(4'b1011, 5'd3, 1'b0, 1'b0);
    push(4'b1110, 5'd1, 1'b0, 1'b1);
    wait_drain("blink_1000");

    // async reset during the digit-2 slot
    load_at_frame({5'd9, 5'd8, 5'd5, 5'd6}, 4'b1111, 4'b0000, 1'b0, 0);
    wait_an(4'b1011, "wait_digit2");
    check("pre_reset_sym_dp", {2'b0, symbol, dp}, {2'b0, 5'd8, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_an", {4'b0, an}, 8'b0000_1111);
    check("async_reset_sym_dp_fs", {1'b0, symbol, dp, frame_start}, 8'd0);
    push(4'b1110, 5'd0, 1'b0, 1'b0);
    push(4'b1101, 5'd0, 1'b0, 1'b0);
    push(4'b1011, 5'd0, 1'b0, 1'b0);
    push(4'b0111, 5'd0, 1'b0, 1'b0);
    push(4'b1110, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_drain("post_reset_scan");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
